// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - byte-addressed RV32I load/store responder with post-reset zero fill
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int INDEX_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        ready,
  input  logic        read_enable,
  input  logic [31:0] read_address,
  input  logic [1:0]  read_size,
  input  logic        read_unsigned,
  output logic [31:0] read_value,
  output logic        read_valid,
  output logic        read_error,
  input  logic        write_enable,
  input  logic [31:0] write_address,
  input  logic [1:0]  write_size,
  input  logic [31:0] write_value,
  output logic        write_error
);

  typedef enum logic {CLEAR, READY} state_t;

  // Byte-address limit; widened so DEPTH_WORDS*4 cannot overflow 32 bits
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(DEPTH_WORDS - 1);

  state_t                 state;
  logic [INDEX_WIDTH-1:0] clear_ptr;
  logic [31:0]            mem [DEPTH_WORDS];

  function automatic logic access_error(input logic [31:0] addr, input logic [1:0] size);
    access_error = (size == 2'b11)
                || (size == 2'b01 && addr[0])
                || (size == 2'b10 && addr[1:0] != 2'b00)
                || ({1'b0, addr} >= LIMIT);
  endfunction

  logic                   rd_err;
  logic                   wr_err;
  logic                   rd_accept;
  logic                   wr_accept;
  logic [INDEX_WIDTH-1:0] rd_index;
  logic [INDEX_WIDTH-1:0] wr_index;
  logic [31:0]            rd_word;
  logic [31:0]            rd_result;
  logic [7:0]             rd_byte;
  logic [15:0]            rd_half;

  assign rd_err    = access_error(read_address, read_size);
  assign wr_err    = access_error(write_address, write_size);
  assign rd_accept = ready & read_enable;
  assign wr_accept = ready & write_enable;
  assign rd_index  = read_address[INDEX_WIDTH+1:2];
  assign wr_index  = write_address[INDEX_WIDTH+1:2];
  assign rd_word   = mem[rd_index];

  always_comb begin
    rd_byte = rd_word[{read_address[1:0], 3'b000} +: 8];
    rd_half = rd_word[{read_address[1], 4'b0000} +: 16];
    case (read_size)
      2'b00:   rd_result = {{24{~read_unsigned & rd_byte[7]}}, rd_byte};
      2'b01:   rd_result = {{16{~read_unsigned & rd_half[15]}}, rd_half};
      2'b10:   rd_result = rd_word;
      default: rd_result = '0;
    endcase
    if (rd_err) rd_result = '0;
  end

  // Storage has no reset; the CLEAR sweep is what zeroes it
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[clear_ptr] <= '0;
    end else if (wr_accept && !wr_err) begin
      case (write_size)
        2'b00:   mem[wr_index][{write_address[1:0], 3'b000} +: 8] <= write_value[7:0];
        2'b01:   mem[wr_index][{write_address[1], 4'b0000} +: 16] <= write_value[15:0];
        default: mem[wr_index] <= write_value;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= CLEAR;
      clear_ptr   <= '0;
      ready       <= 1'b0;
      read_value  <= '0;
      read_valid  <= 1'b0;
      read_error  <= 1'b0;
      write_error <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clear_ptr <= clear_ptr + 1'b1;
          if (clear_ptr == LAST) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= READY;
          ready <= 1'b1;
        end
      endcase

      if (rd_accept) begin
        read_valid <= 1'b1;
        read_error <= rd_err;
        read_value <= rd_result;
      end else begin
        read_valid <= 1'b0;
        read_error <= 1'b0;
      end
      write_error <= wr_accept & wr_err;
    end
  end

endmodule
